// File: rtl/lifter_seq_pkg.sv
// Shared types and constants for the cepstral lifter sequencer.
package lifter_seq_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int IDX_W        = 4;
  localparam int CNT_W        = 5;
  localparam int NUM_COEF_DEF = 13;
  localparam int FCNT_W       = 16;
  localparam int ERR_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/lifter_seq_if.sv
// Coefficient, lifter and MFCC output signals of the lifter sequencer.
interface lifter_seq_if;
  import lifter_seq_pkg::*;

  logic [SAMPLE_W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] lift_data;
  logic                lift_valid;
  logic [IDX_W-1:0]    lift_index;
  logic [SAMPLE_W-1:0] lift_res;
  logic                lift_res_valid;
  logic [SAMPLE_W-1:0] mfcc_out;
  logic                mfcc_out_valid;
  logic [IDX_W-1:0]    mfcc_out_index;
  logic                mfcc_out_last;
  logic                frame_done;
  logic [FCNT_W-1:0]   frame_cnt;
  logic [ERR_W-1:0]    err;

  // sequencer side
  modport slave (
    input  in_data, in_valid, lift_res, lift_res_valid,
    output in_ready, lift_data, lift_valid, lift_index,
           mfcc_out, mfcc_out_valid, mfcc_out_index, mfcc_out_last,
           frame_done, frame_cnt, err
  );

  // upstream producer plus external lifter side
  modport master (
    output in_data, in_valid, lift_res, lift_res_valid,
    input  in_ready, lift_data, lift_valid, lift_index,
           mfcc_out, mfcc_out_valid, mfcc_out_index, mfcc_out_last,
           frame_done, frame_cnt, err
  );

endinterface

// File: rtl/lifter_seq.sv
// Sequences one frame of cepstral coefficients through an external lifter
// multiplier and forwards the liftered results with index/last tagging.
//
// state    | meaning
// ST_IDLE  | waiting for the first coefficient of a frame
// ST_ISSUE | forwarding coefficients to the lifter, collecting results
// ST_DRAIN | all coefficients issued, waiting for remaining results
// ST_DONE  | frame complete, single-cycle frame_done
module lifter_seq
  import lifter_seq_pkg::*;
#(
  parameter int NUM_COEF = NUM_COEF_DEF,
  parameter int LIFT_LAT = 3,
  parameter int TMO_CYC  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  lifter_seq_if.slave bus
);

  // a drain window shorter than the lifter pipeline could never complete
  localparam int TMO_EFF = (TMO_CYC > LIFT_LAT) ? TMO_CYC : LIFT_LAT + 1;
  localparam int TMR_W   = $clog2(TMO_EFF + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_COEF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_COEF - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TMO_EFF);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;

  logic [SAMPLE_W-1:0] lift_data_q;
  logic                lift_valid_q;
  logic [IDX_W-1:0]    lift_index_q;
  logic [SAMPLE_W-1:0] mfcc_out_q;
  logic                mfcc_out_valid_q;
  logic [IDX_W-1:0]    mfcc_out_index_q;
  logic                mfcc_out_last_q;
  logic [FCNT_W-1:0]   frame_cnt_q;
  logic [ERR_W-1:0]    err_q;

  logic in_ready;
  logic frame_done;
  logic xfer;
  logic issue_full;
  logic res_full;
  logic res_ok;
  logic res_bad;
  logic timeout;

  assign xfer       = bus.in_valid & in_ready;
  assign issue_full = (iss_cnt_q == CNT_FULL);
  assign res_full   = (res_cnt_q == CNT_FULL);
  assign res_ok     = bus.lift_res_valid & ((state_q == ST_ISSUE) | (state_q == ST_DRAIN)) & ~res_full;
  assign res_bad    = bus.lift_res_valid & ~res_ok;
  assign timeout    = (state_q == ST_DRAIN) & ~res_full & (tmr_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      iss_cnt_q <= '0;
      res_cnt_q <= '0;
      tmr_q     <= TMR_LOAD;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      res_cnt_q <= res_cnt_d;
      tmr_q     <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (xfer) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (res_full)        state_d = ST_DONE;
        else if (issue_full) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (res_full)     state_d = ST_DONE;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE) | ((state_q == ST_ISSUE) & ~issue_full);
    frame_done = (state_q == ST_DONE);
  end

  // frame bookkeeping: counters restart after DONE or an abandoned drain
  always_comb begin
    iss_cnt_d = iss_cnt_q;
    res_cnt_d = res_cnt_q;
    if (xfer)   iss_cnt_d = iss_cnt_q + CNT_W'(1);
    if (res_ok) res_cnt_d = res_cnt_q + CNT_W'(1);
    if ((state_q == ST_DONE) | timeout) begin
      iss_cnt_d = '0;
      res_cnt_d = '0;
    end
    tmr_d = TMR_LOAD;
    if (state_q == ST_DRAIN) tmr_d = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lift_data_q      <= '0;
      lift_valid_q     <= 1'b0;
      lift_index_q     <= '0;
      mfcc_out_q       <= '0;
      mfcc_out_valid_q <= 1'b0;
      mfcc_out_index_q <= '0;
      mfcc_out_last_q  <= 1'b0;
      frame_cnt_q      <= '0;
      err_q            <= '0;
    end else begin
      lift_valid_q     <= xfer;
      mfcc_out_valid_q <= res_ok;
      if (xfer) begin
        lift_data_q  <= bus.in_data;
        lift_index_q <= iss_cnt_q[IDX_W-1:0];
      end
      if (res_ok) begin
        mfcc_out_q       <= bus.lift_res;
        mfcc_out_index_q <= res_cnt_q[IDX_W-1:0];
        mfcc_out_last_q  <= (res_cnt_q == CNT_LAST);
      end
      if (state_d == ST_DONE) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      err_q <= err_q | {timeout, res_bad};
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.lift_data      = lift_data_q;
  assign bus.lift_valid     = lift_valid_q;
  assign bus.lift_index     = lift_index_q;
  assign bus.mfcc_out       = mfcc_out_q;
  assign bus.mfcc_out_valid = mfcc_out_valid_q;
  assign bus.mfcc_out_index = mfcc_out_index_q;
  assign bus.mfcc_out_last  = mfcc_out_last_q;
  assign bus.frame_done     = frame_done;
  assign bus.frame_cnt      = frame_cnt_q;
  assign bus.err            = err_q;

endmodule
